// File: rtl/vend_pkg.sv
// vend_pkg: types, widths and coin values shared across the vending datapath
//   CREDIT_W      width of credit/price/change values
//   coin_e        coin selector (none, 1, 5 or 10 yuan)
//   disp_state_e  change dispenser FSM states
//   coin_val()    yuan value of a coin selector
package vend_pkg;
  localparam int CREDIT_W = 5;
  typedef enum logic [1:0] {COIN_NONE, COIN_1, COIN_5, COIN_10} coin_e;
  localparam logic [CREDIT_W-1:0] VAL_1 = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] VAL_5 = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] VAL_10 = CREDIT_W'(10);
  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_REJECT, S_VEND, S_PAY, S_COIN, S_GAP, S_SHORT, S_DONE
  } disp_state_e;
  function automatic logic [CREDIT_W-1:0] coin_val(coin_e c);
    return c == COIN_10 ? VAL_10 : c == COIN_5 ? VAL_5 : c == COIN_1 ? VAL_1 : '0;
  endfunction
endpackage

// File: rtl/change_dispenser_if.sv
// change_dispenser_if: request/response bundle between credit FSM and change dispenser
//   master (credit FSM): drives start, credit, price, refill
//   slave (dispenser):   drives vend, reject, chg1/5/10, short_chg, done, busy,
//                        change_owed, stock1/5/10
interface change_dispenser_if #(parameter int STOCK_W = 4);
  import vend_pkg::*;
  logic start;
  logic refill;
  logic [CREDIT_W-1:0] credit;
  logic [CREDIT_W-1:0] price;
  logic vend;
  logic reject;
  logic chg1;
  logic chg5;
  logic chg10;
  logic short_chg;
  logic done;
  logic busy;
  logic [CREDIT_W-1:0] change_owed;
  logic [STOCK_W-1:0] stock1;
  logic [STOCK_W-1:0] stock5;
  logic [STOCK_W-1:0] stock10;
  modport master (
    output start, refill, credit, price,
    input vend, reject, chg1, chg5, chg10, short_chg, done, busy, change_owed, stock1, stock5, stock10
  );
  modport slave (
    input start, refill, credit, price,
    output vend, reject, chg1, chg5, chg10, short_chg, done, busy, change_owed, stock1, stock5, stock10
  );
endinterface

// File: rtl/coin_select.sv
// coin_select: greedy picker, largest coin not above remain that is still in stock
//   remain_i             change still owed
//   stock1/5/10_i        coins left per denomination
//   coin_o               chosen coin, COIN_NONE when no stocked coin fits
module coin_select
  import vend_pkg::*;
#(
  parameter int STOCK_W = 4
) (
  input  logic [CREDIT_W-1:0] remain_i,
  input  logic [STOCK_W-1:0]  stock1_i,
  input  logic [STOCK_W-1:0]  stock5_i,
  input  logic [STOCK_W-1:0]  stock10_i,
  output coin_e               coin_o
);
  assign coin_o = (remain_i >= VAL_10 && stock10_i != '0) ? COIN_10 :
                  (remain_i >= VAL_5 && stock5_i != '0) ? COIN_5 :
                  (remain_i >= VAL_1 && stock1_i != '0) ? COIN_1 : COIN_NONE;
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: vends one item, then pays change as spaced single-coin ejector pulses
//   clk, reset    system clock, asynchronous active-high reset
//   bus (slave)   start/credit/price/refill in; vend/reject/coin/short/done pulses,
//                 busy, change_owed and per-denomination stock out
module change_dispenser
  import vend_pkg::*;
#(
  parameter int STOCK_W = 4,
  parameter int STOCK_INIT = 8,
  parameter int GAP_CYC = 2
) (
  input logic clk,
  input logic reset,
  change_dispenser_if.slave bus
);
  // gap counter runs GAP_CYC-1 down to 0, so GAP lasts exactly GAP_CYC cycles
  localparam int GW = GAP_CYC > 1 ? $clog2(GAP_CYC) : 1;
  localparam logic [STOCK_W-1:0] S_INIT = STOCK_W'(STOCK_INIT);
  localparam logic [GW-1:0] G_INIT = GW'(GAP_CYC - 1);
  disp_state_e state_q, state_d;
  coin_e coin_q, coin_d, pick;
  logic [CREDIT_W-1:0] credit_q, credit_d, price_q, price_d, remain_q, remain_d;
  logic [STOCK_W-1:0] s1_q, s1_d, s5_q, s5_d, s10_q, s10_d;
  logic [GW-1:0] gap_q, gap_d;
  coin_select #(.STOCK_W(STOCK_W)) u_sel (
    .remain_i(remain_q),
    .stock1_i(s1_q),
    .stock5_i(s5_q),
    .stock10_i(s10_q),
    .coin_o(pick)
  );
  always_comb begin
    state_d = state_q;
    coin_d = coin_q;
    credit_d = credit_q;
    price_d = price_q;
    remain_d = remain_q;
    s1_d = s1_q;
    s5_d = s5_q;
    s10_d = s10_q;
    gap_d = gap_q;
    case (state_q)
      S_IDLE: begin
        // start wins over a simultaneous refill, which is dropped
        if (bus.start) begin
          credit_d = bus.credit;
          price_d = bus.price;
          state_d = S_CHECK;
        end else if (bus.refill) begin
          s1_d = S_INIT;
          s5_d = S_INIT;
          s10_d = S_INIT;
        end
      end
      S_CHECK: begin
        if (credit_q < price_q) state_d = S_REJECT;
        else begin
          remain_d = credit_q - price_q;
          state_d = S_VEND;
        end
      end
      S_VEND: state_d = S_PAY;
      S_PAY: begin
        if (remain_q == '0) state_d = S_DONE;
        else if (pick == COIN_NONE) state_d = S_SHORT;
        else begin
          coin_d = pick;
          state_d = S_COIN;
        end
      end
      S_COIN: begin
        remain_d = remain_q - coin_val(coin_q);
        s1_d = coin_q == COIN_1 ? s1_q - 1'b1 : s1_q;
        s5_d = coin_q == COIN_5 ? s5_q - 1'b1 : s5_q;
        s10_d = coin_q == COIN_10 ? s10_q - 1'b1 : s10_q;
        gap_d = G_INIT;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_PAY;
        else gap_d = gap_q - 1'b1;
      end
      S_SHORT: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      coin_q <= COIN_NONE;
      credit_q <= '0;
      price_q <= '0;
      remain_q <= '0;
      s1_q <= S_INIT;
      s5_q <= S_INIT;
      s10_q <= S_INIT;
      gap_q <= '0;
    end else begin
      state_q <= state_d;
      coin_q <= coin_d;
      credit_q <= credit_d;
      price_q <= price_d;
      remain_q <= remain_d;
      s1_q <= s1_d;
      s5_q <= s5_d;
      s10_q <= s10_d;
      gap_q <= gap_d;
    end
  end
  assign bus.vend = state_q == S_VEND;
  assign bus.reject = state_q == S_REJECT;
  assign bus.chg1 = state_q == S_COIN && coin_q == COIN_1;
  assign bus.chg5 = state_q == S_COIN && coin_q == COIN_5;
  assign bus.chg10 = state_q == S_COIN && coin_q == COIN_10;
  assign bus.short_chg = state_q == S_SHORT;
  assign bus.done = state_q == S_DONE;
  assign bus.busy = state_q != S_IDLE;
  assign bus.change_owed = remain_q;
  assign bus.stock1 = s1_q;
  assign bus.stock5 = s5_q;
  assign bus.stock10 = s10_q;
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: scoreboard bench; expected pulses are queued per transaction and
// a monitor pops one for every pulse the dispenser raises, checking kind, change_owed and spacing
module tb_change_dispenser;
  import vend_pkg::*;
  localparam int GAP = 2;
  localparam int LAT = 2;
  localparam int E_VEND = 0, E_REJECT = 1, E_C1 = 2, E_C5 = 3, E_C10 = 4, E_SHORT = 5, E_DONE = 6;
  typedef struct {
    int kind;
    int owed;
    int delta;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  exp_t q[$];
  change_dispenser_if #(.STOCK_W(4)) bus ();
  change_dispenser #(.STOCK_W(4), .STOCK_INIT(8), .GAP_CYC(GAP)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask
  function automatic int pulses();
    return int'(bus.vend) + int'(bus.reject) + int'(bus.chg1) + int'(bus.chg5) +
           int'(bus.chg10) + int'(bus.short_chg) + int'(bus.done);
  endfunction
  task automatic push(input int kind, input int owed, input int delta);
    exp_t e;
    e.kind = kind;
    e.owed = owed;
    e.delta = delta;
    q.push_back(e);
  endtask
  // vend/reject spacing is measured from the cycle start is raised, everything else from the previous pulse
  task automatic monitor();
    int n, kind, last_cyc;
    exp_t e;
    last_cyc = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        n = pulses();
        if (n > 1) chk("pulse_onehot", n, 1);
        if (n > 0) begin
          kind = bus.vend ? E_VEND : bus.reject ? E_REJECT : bus.chg1 ? E_C1 : bus.chg5 ? E_C5 :
                 bus.chg10 ? E_C10 : bus.short_chg ? E_SHORT : E_DONE;
          if (q.size() == 0) chk("unexpected_event", kind, -1);
          else begin
            e = q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("change_owed", int'(bus.change_owed), e.owed);
            chk("event_spacing", cyc - ((kind == E_VEND || kind == E_REJECT) ? start_cyc : last_cyc), e.delta);
          end
          last_cyc = cyc;
        end
      end
    end
  endtask
  task automatic txn(input int cr, input int pr, input bit rf);
    @(negedge clk);
    start_cyc = cyc;
    bus.credit = CREDIT_W'(cr);
    bus.price = CREDIT_W'(pr);
    bus.refill = rf;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.refill = 1'b0;
  endtask
  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle_reached", int'(bus.busy), 0);
    chk("queue_drained", q.size(), 0);
  endtask
  task automatic coins(input int kind, input int val, input int cnt, inout int owed, inout int d);
    for (int i = 0; i < cnt; i++) begin
      push(kind, owed, d);
      owed -= val;
      d = GAP + 2;
    end
  endtask
  // n10/n5/n1 are the hand-computed greedy coin counts for this vend
  task automatic run(input int cr, pr, n10, n5, n1, input bit sh, rf, poke, output int bc);
    int owed, d;
    owed = cr - pr;
    d = 2;
    push(E_VEND, owed, LAT);
    coins(E_C10, 10, n10, owed, d);
    coins(E_C5, 5, n5, owed, d);
    coins(E_C1, 1, n1, owed, d);
    if (sh) begin
      push(E_SHORT, owed, d);
      d = 1;
    end
    push(E_DONE, owed, d);
    txn(cr, pr, rf);
    if (poke) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.credit = CREDIT_W'(3);
      bus.price = '0;
      bus.refill = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.refill = 1'b0;
    end
    wait_idle(bc);
  endtask
  task automatic chk_stock(input int s10, input int s5, input int s1);
    chk("stock10", int'(bus.stock10), s10);
    chk("stock5", int'(bus.stock5), s5);
    chk("stock1", int'(bus.stock1), s1);
  endtask
  task automatic do_refill();
    @(negedge clk);
    bus.refill = 1'b1;
    @(negedge clk);
    bus.refill = 1'b0;
  endtask
  initial begin
    int n;
    bus.start = 1'b0;
    bus.refill = 1'b0;
    bus.credit = '0;
    bus.price = '0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_owed", int'(bus.change_owed), 0);
    chk("rst_pulses", pulses(), 0);
    chk_stock(8, 8, 8);
    reset = 1'b0;
    run(20, 7, 1, 0, 3, 0, 0, 0, n);
    chk_stock(7, 8, 5);
    push(E_REJECT, 0, LAT);
    txn(4, 9, 0);
    wait_idle(n);
    chk_stock(7, 8, 5);
    run(12, 12, 0, 0, 0, 0, 0, 0, n);
    chk("exact_busy_cycles", n, 4);
    do_refill();
    chk_stock(8, 8, 8);
    run(31, 1, 3, 0, 0, 0, 0, 0, n);
    run(30, 0, 3, 0, 0, 0, 0, 0, n);
    run(20, 0, 2, 0, 0, 0, 0, 0, n);
    chk_stock(0, 8, 8);
    run(15, 0, 0, 3, 0, 0, 0, 1, n);
    chk_stock(0, 5, 8);
    run(25, 0, 0, 5, 0, 0, 0, 0, n);
    run(6, 0, 0, 0, 6, 0, 0, 0, n);
    chk_stock(0, 0, 2);
    run(8, 0, 0, 0, 2, 1, 0, 0, n);
    chk("short_residual", int'(bus.change_owed), 6);
    chk_stock(0, 0, 0);
    push(E_REJECT, 6, LAT);
    txn(2, 5, 0);
    wait_idle(n);
    chk("reject_keeps_owed", int'(bus.change_owed), 6);
    run(5, 5, 0, 0, 0, 0, 1, 0, n);
    chk("owed_cleared", int'(bus.change_owed), 0);
    chk_stock(0, 0, 0);
    do_refill();
    chk_stock(8, 8, 8);
    push(E_VEND, 31, LAT);
    push(E_C10, 31, 2);
    push(E_C10, 21, GAP + 2);
    txn(31, 0, 0);
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("mid_pay_events", q.size(), 0);
    #3 reset = 1'b1;
    #1;
    chk("rst_mid_pulses", pulses(), 0);
    chk("rst_mid_busy", int'(bus.busy), 0);
    chk("rst_mid_owed", int'(bus.change_owed), 0);
    chk_stock(8, 8, 8);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_reset_idle", int'(bus.busy), 0);
    run(12, 12, 0, 0, 0, 0, 0, 0, n);
    chk("post_reset_busy_cycles", n, 4);
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
